// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with a
// timeout-and-retry loop, qualifies lock stability, then releases sys reset.
// Ports: CLK/RST_N board clock + async reset; pll_locked async lock input;
// soft_reset_req restart pulse; pll_rst, sys_rst_n, ready control outputs;
// state debug code; timeout_count/lock_loss_count saturating diagnostics.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] timeout_count,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_AB =
    (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
    RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_P =
    (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST =
    CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [7:0]    tmo_q, tmo_d;
  logic [7:0]    loss_q, loss_d;
  logic          tmo_inc, loss_inc;
  logic          pll_rst_q, sys_rst_n_q, ready_q;

  // pll_locked comes from the PLL's own domain; resynchronise it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // Next-state logic; a soft request overrides every other transition
  always_comb begin
    state_d  = state_q;
    tmo_inc  = 1'b0;
    loss_inc = 1'b0;
    if (soft_reset_req) begin
      state_d = S_RESET;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            state_d = S_RESET;
            tmo_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_WAIT;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d  = S_RESET;
            loss_inc = 1'b1;
          end
        end
        default: begin
          state_d = S_RESET;
        end
      endcase
    end
  end

  // Shared cycle counter: cleared on any state change or soft request,
  // held in RUN where it has no meaning
  always_comb begin
    cnt_d = cnt_q;
    if (soft_reset_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q != S_RUN) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    tmo_d  = tmo_q;
    loss_d = loss_q;
    if (tmo_inc && (tmo_q != 8'hFF)) begin
      tmo_d = tmo_q + 8'd1;
    end
    if (loss_inc && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      tmo_q   <= 8'd0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      loss_q  <= loss_d;
    end
  end

  // Outputs decode the next state into flops so they switch on the
  // same edge as state and never glitch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == S_RESET);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst_n       = sys_rst_n_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign timeout_count   = tmo_q;
  assign lock_loss_count = loss_q;

endmodule
